uart_mem_bridge: RTL and testbench

Serial command responder that lets an external host read and write the 8-bit data memory over the same 8N1 UART link the CPU uses for its memory-mapped port. Contains its own receive deserializer, transmit serializer and command state machine. Drives a memory port that the top level muxes onto the data memory in place of the CPU while `busy` is high. Used for program/data loading and debug inspection.

---
 rtl/uart_mem_bridge.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_bridge
// Description : 8N1 UART command responder ('W' addr data / 'R' addr) that
//               reads and writes an 8-bit data memory for load and debug.
//               Optional inter-byte timeout: define UART_BRIDGE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_bridge #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_w_data,
    output logic       mem_w_en,
    input  logic [7:0] mem_r_data,
    output logic       busy,
    output logic       frame_err
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [7:0] c_CMD_WRITE = 8'h57;
    localparam logic [7:0] c_CMD_READ  = 8'h52;
    localparam logic [7:0] c_ACK       = 8'h06;
    localparam logic [7:0] c_NAK       = 8'h15;

    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_GET_ADDR  = 3'd1;
    localparam logic [2:0] c_S_GET_DATA  = 3'd2;
    localparam logic [2:0] c_S_WRITE     = 3'd3;
    localparam logic [2:0] c_S_READ      = 3'd4;
    localparam logic [2:0] c_S_READ_WAIT = 3'd5;
    localparam logic [2:0] c_S_SEND      = 3'd6;
    localparam logic [2:0] c_S_WAIT_TX   = 3'd7;

    // ------------------------------------------------------------------
    // Receive deserializer
    // ------------------------------------------------------------------
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    logic [1:0]         r_rx_state;
    logic [c_CNT_W-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;
    logic               r_rx_valid;
    logic               r_frame_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_state  <= c_RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta   <= rx;
            r_rx_sync   <= r_rx_meta;
            r_rx_prev   <= r_rx_sync;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_rx_state)
                c_RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= c_RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                c_RX_START: begin
                    // Line back high at mid start bit means a glitch.
                    if (r_rx_cnt == c_HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= r_rx_sync ? c_RX_IDLE : c_RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                c_RX_DATA: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= c_RX_STOP;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt    <= '0;
                        r_rx_state  <= c_RX_IDLE;
                        r_rx_valid  <= r_rx_sync;
                        r_frame_err <= !r_rx_sync;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit serializer
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [7:0]         r_reply;
    logic               r_tx;
    logic               r_tx_active;
    logic [8:0]         r_tx_shift;
    logic [3:0]         r_tx_bit;
    logic [c_CNT_W-1:0] r_tx_cnt;
    logic               w_tx_done;

    assign w_tx_done = r_tx_active && (r_tx_bit == 4'd9) && (r_tx_cnt == c_BIT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx        <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_shift  <= 9'h1FF;
            r_tx_bit    <= 4'd0;
            r_tx_cnt    <= '0;
        end else if (!r_tx_active) begin
            r_tx <= 1'b1;
            if (r_state == c_S_SEND) begin
                r_tx_active <= 1'b1;
                r_tx        <= 1'b0;
                r_tx_shift  <= {1'b1, r_reply};
                r_tx_bit    <= 4'd0;
                r_tx_cnt    <= '0;
            end
        end else if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 4'd9) begin
                r_tx_active <= 1'b0;
                r_tx        <= 1'b1;
            end else begin
                r_tx_bit   <= r_tx_bit + 1'b1;
                r_tx       <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte timeout
    // ------------------------------------------------------------------
    logic w_timeout;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int                c_TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int                c_TO_W      = $clog2(c_TO_CYCLES);
    localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(c_TO_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_waiting;

    assign w_waiting = (r_state == c_S_GET_ADDR) || (r_state == c_S_GET_DATA);

    always_ff @(posedge clock) begin
        if (reset || !w_waiting || r_rx_valid) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_LAST) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = w_waiting && !r_rx_valid && (r_to_cnt == c_TO_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_BITS > 0);
    assign w_timeout        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Command state machine
    // ------------------------------------------------------------------
    logic       r_is_write;
    logic [7:0] r_addr_buf;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_w_data;
    logic       r_mem_w_en;
    logic       r_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_reply      <= 8'h00;
            r_is_write   <= 1'b0;
            r_addr_buf   <= 8'h00;
            r_mem_addr   <= 8'h00;
            r_mem_w_data <= 8'h00;
            r_mem_w_en   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_mem_w_en <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (r_rx_valid) begin
                        if (r_rx_shift == c_CMD_WRITE || r_rx_shift == c_CMD_READ) begin
                            r_is_write <= (r_rx_shift == c_CMD_WRITE);
                            r_busy     <= 1'b1;
                            r_state    <= c_S_GET_ADDR;
                        end else begin
                            r_reply <= c_NAK;
                            r_state <= c_S_SEND;
                        end
                    end
                end
                c_S_GET_ADDR: begin
                    if (w_timeout) begin
                        r_busy  <= 1'b0;
                        r_state <= c_S_IDLE;
                    end else if (r_rx_valid) begin
                        if (r_is_write) begin
                            r_addr_buf <= r_rx_shift;
                            r_state    <= c_S_GET_DATA;
                        end else begin
                            // Address presented during READ so synchronous RAM data lands in READ_WAIT.
                            r_mem_addr <= r_rx_shift;
                            r_state    <= c_S_READ;
                        end
                    end
                end
                c_S_GET_DATA: begin
                    if (w_timeout) begin
                        r_busy  <= 1'b0;
                        r_state <= c_S_IDLE;
                    end else if (r_rx_valid) begin
                        r_mem_addr   <= r_addr_buf;
                        r_mem_w_data <= r_rx_shift;
                        r_mem_w_en   <= 1'b1;
                        r_state      <= c_S_WRITE;
                    end
                end
                c_S_WRITE: begin
                    r_reply <= c_ACK;
                    r_state <= c_S_SEND;
                end
                c_S_READ: begin
                    r_state <= c_S_READ_WAIT;
                end
                c_S_READ_WAIT: begin
                    r_reply <= mem_r_data;
                    r_state <= c_S_SEND;
                end
                c_S_SEND: begin
                    r_state <= c_S_WAIT_TX;
                end
                default: begin
                    if (w_tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= c_S_IDLE;
                    end
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign mem_addr   = r_mem_addr;
    assign mem_w_data = r_mem_w_data;
    assign mem_w_en   = r_mem_w_en;
    assign busy       = r_busy;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mem_bridge
// Description : Self-checking bench for uart_mem_bridge at CLKS_PER_BIT = 8,
//               with an attached RAM, a UART reply decoder and a command model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mem_bridge;

    localparam int c_CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       tx;
    logic [7:0] mem_addr;
    logic [7:0] mem_w_data;
    logic       mem_w_en;
    logic [7:0] mem_r_data;
    logic       busy;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_mem_bridge #(
        .CLKS_PER_BIT(c_CPB),
        .TIMEOUT_BITS(20)
    ) u_dut (
        .clock      (clk),
        .reset      (rst),
        .rx         (rx),
        .tx         (tx),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .mem_w_en   (mem_w_en),
        .mem_r_data (mem_r_data),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    // Synchronous data RAM the bridge owns while busy; bench preloads via pl_*.
    logic [7:0] ram [256];
    logic       pl_en   = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data = 8'h00;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_w_en) ram[mem_addr] <= mem_w_data;
        mem_r_data <= ram[mem_addr];
    end

    // Model: expected memory image, expected write strobes and reply bytes.
    logic [7:0]  model_mem [256];
    logic [15:0] exp_w [$];
    logic [7:0]  exp_r [$];
    logic [7:0]  got_q [$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_writes = 0;
    int   n_ferr = 0;
    bit   saw_busy = 0;
    bit   mon_en = 1;
    logic [7:0] last_reply = 8'h00;
    logic [7:0] mon_byte;
    logic [15:0] w_pop;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Decode reply frames on tx, sampling mid-bit.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst && tx === 1'b0) begin
                repeat (c_CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (c_CPB) @(negedge clk);
                    mon_byte[i] = tx;
                end
                repeat (c_CPB) @(negedge clk);
                if (mon_en) begin
                    check("tx_stop_bit", {15'd0, tx}, 16'd1);
                    got_q.push_back(mon_byte);
                end
            end
        end
    end

    // Single compare process against the model queues.
    always @(negedge clk) begin
        if (!rst && mem_w_en) begin
            n_writes++;
            check("write_expected", {15'd0, exp_w.size() > 0}, 16'd1);
            if (exp_w.size() > 0) begin
                w_pop = exp_w.pop_front();
                check("write_addr_data", {mem_addr, mem_w_data}, w_pop);
            end
        end
        if (got_q.size() > 0) begin
            last_reply = got_q.pop_front();
            check("reply_expected", {15'd0, exp_r.size() > 0}, 16'd1);
            if (exp_r.size() > 0) check("reply_byte", {8'd0, last_reply}, {8'd0, exp_r.pop_front()});
        end
        if (busy) saw_busy = 1;
        if (frame_err) n_ferr++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) rx = 1'b0;
        repeat (c_CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rx = b[i];
            repeat (c_CPB - 1) @(negedge clk);
        end
        @(negedge clk) rx = stop_bit;
        repeat (c_CPB - 1) @(negedge clk);
        @(negedge clk) rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!busy && exp_r.size() == 0 && exp_w.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("cmd_complete", {15'd0, ok}, 16'd1);
        repeat (20) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        exp_w.push_back({a, d});
        exp_r.push_back(8'h06);
        model_mem[a] = d;
        send_byte(8'h57, 1'b1);
        send_byte(a, 1'b1);
        send_byte(d, 1'b1);
        wait_done();
    endtask

    task automatic do_read(input logic [7:0] a);
        exp_r.push_back(model_mem[a]);
        send_byte(8'h52, 1'b1);
        send_byte(a, 1'b1);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wcount;
        int low_cycles;
        bit ok;
        rst = 1'b1;
        rx  = 1'b1;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_tx", {15'd0, tx}, 16'd1);
        check("reset_mem_addr", {8'd0, mem_addr}, 16'd0);
        check("reset_mem_w_data", {8'd0, mem_w_data}, 16'd0);
        check("reset_mem_w_en", {15'd0, mem_w_en}, 16'd0);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_frame_err", {15'd0, frame_err}, 16'd0);
        rst = 1'b0;
        preload(8'h00, 8'h5A);
        preload(8'h20, 8'hC3);
        repeat (10) @(negedge clk);

        // Write command
        do_write(8'h10, 8'hA5);
        check("write_ack_literal", {8'd0, last_reply}, 16'h0006);
        check("write_ram_literal", {8'd0, ram[8'h10]}, 16'h00A5);
        check("write_addr_hold", {8'd0, mem_addr}, 16'h0010);
        check("write_strobe_count", n_writes[15:0], 16'd1);
        check("write_busy_low", {15'd0, busy}, 16'd0);

        // Read command of preloaded data
        preload(8'h10, 8'h3C);
        wcount = n_writes;
        do_read(8'h10);
        check("read_literal", {8'd0, last_reply}, 16'h003C);
        check("read_no_write", n_writes[15:0], wcount[15:0]);

        // Unknown command gives NAK without busy
        saw_busy = 0;
        exp_r.push_back(8'h15);
        send_byte(8'h41, 1'b1);
        wait_done();
        check("nak_literal", {8'd0, last_reply}, 16'h0015);
        check("nak_no_busy", {15'd0, saw_busy}, 16'd0);
        check("nak_no_write", n_writes[15:0], wcount[15:0]);

        // Bad stop bit: frame_err pulse, byte discarded
        n_ferr = 0;
        saw_busy = 0;
        send_byte(8'h57, 1'b0);
        repeat (40) @(negedge clk);
        check("frame_err_pulse", n_ferr[15:0], 16'd1);
        check("frame_err_no_busy", {15'd0, saw_busy}, 16'd0);
        do_read(8'h00);
        check("read_after_ferr_literal", {8'd0, last_reply}, 16'h005A);

        // Two-cycle glitch is not a start bit
        saw_busy = 0;
        n_ferr = 0;
        @(negedge clk) rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_busy", {15'd0, saw_busy}, 16'd0);
        check("glitch_no_ferr", n_ferr[15:0], 16'd0);
        do_read(8'h20);
        check("read_after_glitch_literal", {8'd0, last_reply}, 16'h00C3);

        // Boundary addresses and data
        do_write(8'hFF, 8'h00);
        do_write(8'h00, 8'hFF);
        do_read(8'hFF);
        do_read(8'h00);
        check("read_00_literal", {8'd0, last_reply}, 16'h00FF);

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Partial command abandoned after the inter-byte timeout
        wcount = n_writes;
        send_byte(8'h57, 1'b1);
        send_byte(8'h20, 1'b1);
        check("timeout_busy_before", {15'd0, busy}, 16'd1);
        repeat (200) @(negedge clk);
        check("timeout_busy_dropped", {15'd0, busy}, 16'd0);
        check("timeout_no_write", n_writes[15:0], wcount[15:0]);
        do_read(8'h20);
        check("timeout_mem_kept", {8'd0, last_reply}, 16'h00C3);
`else
        // Partial command waits indefinitely, then completes
        exp_w.push_back({8'h20, 8'h77});
        exp_r.push_back(8'h06);
        model_mem[8'h20] = 8'h77;
        send_byte(8'h57, 1'b1);
        send_byte(8'h20, 1'b1);
        repeat (200) @(negedge clk);
        check("partial_busy_held", {15'd0, busy}, 16'd1);
        send_byte(8'h77, 1'b1);
        wait_done();
        check("partial_ram_literal", {8'd0, ram[8'h20]}, 16'h0077);
`endif

        // Reset in the middle of a reply frame
        mon_en = 0;
        send_byte(8'h52, 1'b1);
        send_byte(8'h10, 1'b1);
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1;
                break;
            end
        end
        check("midreply_started", {15'd0, ok}, 16'd1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreply_tx_high", {15'd0, tx}, 16'd1);
        check("midreply_busy_low", {15'd0, busy}, 16'd0);
        rst = 1'b0;
        low_cycles = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) low_cycles++;
        end
        check("post_reset_quiet", low_cycles[15:0], 16'd0);
        mon_en = 1;
        do_read(8'h10);
        check("post_reset_read_literal", {8'd0, last_reply}, 16'h003C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
